// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, occupancy,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end
    if (DATA_W < 1) begin : g_bad_w
      $error("sync_fifo_param: DATA_W must be >= 1");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Acceptance is decided from the pre-edge flags only, so a full FIFO
  // never takes a write even when a read frees a slot in the same cycle.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
        end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end else begin : g_fwft_read
      // Head word is presented continuously; rd_en only pops it.
      assign rd_data  = r_mem[r_rd_ptr];
      assign rd_valid = ~w_empty;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_sync_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1;
  logic [4:0]    count0, count1;
  logic          ovf0, ovf1, udf0, udf1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: contents as a queue, read-port state as plain variables.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;
  logic          m_ovf;
  logic          m_udf;
  bit            m_ready = 1'b0;

  always @(posedge clk) begin
    bit was_full;
    bit was_empty;
    if (rst) begin
      q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
      m_ready    = 1'b1;
    end else begin
      was_full   = (q.size() == DEPTH);
      was_empty  = (q.size() == 0);
      m_ovf      = wr_en && was_full;
      m_udf      = rd_en && was_empty;
      m_rd_valid = rd_en && !was_empty;
      if (m_rd_valid) m_rd_data = q.pop_front();
      if (wr_en && !was_full) q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    int n;
    if (m_ready) begin
      n = q.size();
      chk("count0", count0, n);
      chk("count1", count1, n);
      chk("full0", full0, n == DEPTH);
      chk("full1", full1, n == DEPTH);
      chk("empty0", empty0, n == 0);
      chk("empty1", empty1, n == 0);
      chk("af0", af0, n >= AF);
      chk("ae0", ae0, n <= AE);
      chk("af1", af1, n >= AF);
      chk("ae1", ae1, n <= AE);
      chk("ovf0", ovf0, m_ovf);
      chk("udf0", udf0, m_udf);
      chk("ovf1", ovf1, m_ovf);
      chk("udf1", udf1, m_udf);
      chk("rd_valid0", rd_valid0, m_rd_valid);
      chk("rd_data0", rd_data0, m_rd_data);
      chk("rd_valid1", rd_valid1, n != 0);
      if (n != 0) chk("rd_data1", rd_data1, q[0]);
    end
  end

  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0);
    chk("lit_rst_count", count0, 0);
    chk("lit_rst_empty", empty0, 1);
    chk("lit_rst_ae", ae0, 1);
    chk("lit_rst_full", full0, 0);
    chk("lit_rst_af", af0, 0);
    chk("lit_rst_valid", rd_valid0, 0);
    chk("lit_rst_data", rd_data0, 0);
    chk("lit_rst_ovf", ovf0, 0);
    chk("lit_rst_udf", udf0, 0);

    // Fill to full, then one rejected write
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 12) chk("lit_af_13", af0, 0);
      if (i == 13) chk("lit_af_14", af0, 1);
    end
    chk("lit_full", full0, 1);
    chk("lit_count16", count0, 16);
    step(1'b1, 32'hFF, 1'b0);
    chk("lit_ovf_pulse", ovf0, 1);
    chk("lit_ovf_count", count0, 16);
    step(1'b0, '0, 1'b0);
    chk("lit_ovf_clear", ovf0, 0);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      chk("lit_rd_seq", rd_data0, i);
      chk("lit_rd_valid", rd_valid0, 1);
    end
    step(1'b0, '0, 1'b0);
    chk("lit_rd_idle_valid", rd_valid0, 0);
    chk("lit_drained", empty0, 1);

    // Pointer wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h100 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1);
      chk("lit_wrap_a", rd_data0, 32'h100 + i);
    end
    for (int i = 0; i < 16; i++) step(1'b1, DW'(32'h200 + i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      chk("lit_wrap_b", rd_data0, 32'h200 + i);
    end
    chk("lit_wrap_count", count0, 0);

    // Steady simultaneous read/write at count=5
    for (int i = 0; i < 5; i++) step(1'b1, DW'(32'h300 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(32'h400 + i), 1'b1);
      chk("lit_both_count", count0, 5);
      chk("lit_both_data", rd_data0, (i < 5) ? (32'h300 + i) : (32'h400 + i - 5));
    end
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Both asserted at empty and at full
    step(1'b1, 32'h500, 1'b1);
    chk("lit_empty_both_count", count0, 1);
    chk("lit_empty_both_udf", udf0, 1);
    step(1'b0, '0, 1'b0);
    chk("lit_udf_clear", udf0, 0);
    for (int i = 0; i < 15; i++) step(1'b1, DW'(32'h501 + i), 1'b0);
    step(1'b1, 32'h5FF, 1'b1);
    chk("lit_full_both_count", count0, 15);
    chk("lit_full_both_ovf", ovf0, 1);
    chk("lit_full_both_data", rd_data0, 32'h500);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);

    // FWFT presentation without rd_en
    step(1'b1, 32'hA5A5A5A5, 1'b0);
    chk("lit_fwft_valid", rd_valid1, 1);
    chk("lit_fwft_data", rd_data1, 32'hA5A5A5A5);
    chk("lit_std_no_valid", rd_valid0, 0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("lit_fwft_pop_empty", empty1, 1);
    chk("lit_fwft_pop_valid", rd_valid1, 0);
    chk("lit_std_pop_data", rd_data0, 32'hA5A5A5A5);

    // Reset mid-operation with both requests high
    for (int i = 0; i < 9; i++) step(1'b1, DW'(32'h600 + i), 1'b0);
    chk("lit_pre_rst_count", count0, 9);
    rst = 1'b1;
    step(1'b1, 32'h777, 1'b1);
    chk("lit_mid_rst_count", count0, 0);
    chk("lit_mid_rst_empty", empty0, 1);
    chk("lit_mid_rst_valid", rd_valid0, 0);
    chk("lit_mid_rst_valid1", rd_valid1, 0);
    rst = 1'b0;
    step(1'b1, 32'hBEEF, 1'b0);
    chk("lit_post_rst_fwft", rd_data1, 32'hBEEF);
    step(1'b0, '0, 1'b1);
    chk("lit_post_rst_data", rd_data0, 32'hBEEF);
    chk("lit_post_rst_empty", empty0, 1);
    repeat (2) step(1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
